mem_port_arbiter: RTL

Shares one single-ported unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (D).
- Arbitrates requests and runs a req/gnt/rvalid handshake with the memory, one transaction outstanding.
- Returns read data and completion pulses to each stage.
- Produces per-stage stall signals that the hazard logic ORs into its own stall terms.
- Data has priority, but an anti-starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
//   arb_state_t : arbiter FSM state (idle arbitration, request phase, response wait)
//   arb_owner_t : which pipeline stage owns the transaction in flight
//   addr_t/data_t : default-width address and data words
package mem_port_arbiter_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  typedef logic [DefaultAddrW-1:0] addr_t;
  typedef logic [DefaultDataW-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    IF,
    D
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch stage (IF) and the
// memory stage (D), one transaction outstanding, req/gnt/rvalid handshake.
//   clk, reset                      : clock, synchronous active-low reset
//   if_req/if_addr/if_kill          : fetch request, address, redirect flush
//   if_rdata/if_valid/if_stall      : fetch data, completion pulse, stall
//   d_req/d_we/d_be/d_addr/d_wdata  : data access request
//   d_rdata/d_valid/d_stall         : load data, completion pulse, stall
//   mem_req/we/be/addr/wdata        : registered memory request
//   mem_gnt/mem_rvalid/mem_rdata    : memory accept, response, read data
//   err_timeout                     : sticky flag, transaction outstanding too long
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_timeout
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int unsigned ToW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic                drop_q, drop_d;
  logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [BeW-1:0]      mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic if_elig, both_elig, grant_if, grant_d;

  // A killed fetch is not eligible; fetch beats data only once it has lost MAX_WAIT times.
  assign if_elig   = if_req && !if_kill;
  assign both_elig = if_elig && d_req;
  assign grant_if  = (state_q == IDLE) && if_elig && (!d_req || (wait_cnt_q == WaitMax));
  assign grant_d   = (state_q == IDLE) && d_req && !grant_if;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      drop_q      <= 1'b0;
      wait_cnt_q  <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      wait_cnt_q  <= wait_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_if || grant_d) state_d = REQ;
      REQ:     if (mem_gnt)             state_d = WAIT;
      WAIT:    if (mem_rvalid)          state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Registered datapath and counter updates.
  always_comb begin
    owner_d     = owner_q;
    drop_d      = drop_q;
    wait_cnt_d  = wait_cnt_q;
    to_cnt_d    = to_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (grant_if) begin
      owner_d     = IF;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_be_d    = '1;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
    end else if (grant_d) begin
      owner_d     = D;
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_be_d    = d_we ? d_be : '1;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end

    if ((state_q == REQ) && mem_gnt) mem_req_d = 1'b0;

    // Only a contested loss by fetch counts toward starvation.
    if (grant_if) begin
      wait_cnt_d = '0;
    end else if (both_elig && grant_d && (wait_cnt_q != WaitMax)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // The memory side still completes a killed fetch; only its result is discarded.
    if ((state_q != IDLE) && (owner_q == IF) && if_kill) drop_d = 1'b1;
    if ((state_q == WAIT) && mem_rvalid) begin
      drop_d  = 1'b0;
      owner_d = NONE;
    end

    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToMax) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Timeout flag is sticky; the FSM keeps waiting regardless.
  always_comb begin
    err_d = err_q;
    if ((TIMEOUT != 0) && (state_q != IDLE) && (to_cnt_q == ToMax)) err_d = 1'b1;
  end

  // Outputs.
  always_comb begin
    if_valid    = mem_rvalid && (state_q == WAIT) && (owner_q == IF) && !drop_q;
    d_valid     = mem_rvalid && (state_q == WAIT) && (owner_q == D);
    if_rdata    = mem_rdata;
    d_rdata     = mem_rdata;
    if_stall    = if_req && !if_valid && !if_kill;
    d_stall     = d_req && !d_valid;
    mem_req     = mem_req_q;
    mem_we      = mem_we_q;
    mem_be      = mem_be_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    err_timeout = err_q;
  end

endmodule
